// File: rtl/queue_pack_ctrl.sv
// queue_pack_ctrl
//   Feeds an external 4x8-bit shift queue from a byte stream. Each byte it
//   accepts becomes one single-cycle ENA pulse into the queue. After four
//   shifts, the queue's 32-bit word is presented on a valid/ready output port.
//   A partial word is padded with PAD_BYTE and emitted. This happens on an
//   explicit FLUSH or after TIMEOUT_CYC idle cycles.
//
// Ports
//   CLK, RST               clock (rising edge), async active-high reset
//   IN_VALID/IN_DATA/IN_READY   byte source handshake
//   FLUSH                  single-cycle request to emit the partial word
//   Q_ENA, Q_DATAIN        drive the queue (shift on ENA rising edge)
//   Q_DATAOUT              queue contents, oldest byte in [31:24]
//   OUT_VALID/OUT_DATA/OUT_READY  word consumer handshake
//   OUT_BYTES              number of real (non-pad) bytes in OUT_DATA, 1..4

module queue_pack_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    input  logic        FLUSH,
    output logic        Q_ENA,
    output logic [7:0]  Q_DATAIN,
    input  logic [31:0] Q_DATAOUT,
    output logic        OUT_VALID,
    output logic [31:0] OUT_DATA,
    output logic [2:0]  OUT_BYTES,
    input  logic        OUT_READY
);

    localparam int unsigned IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, PAD, PADGAP, HOLD} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      real_cnt_q, real_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            q_ena_q, q_ena_d;
    logic [7:0]      q_datain_q, q_datain_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [2:0]      out_bytes_q, out_bytes_d;
    logic            accept;
    logic            partial;
    logic            capture;

    assign IN_READY  = ((state_q == IDLE) || (state_q == GAP)) && (cnt_q < 3'd4)
                       && !flush_pend_q && !RST;
    assign accept    = IN_VALID && IN_READY;
    assign partial   = (cnt_q != 3'd0) && (cnt_q < 3'd4);

    assign Q_ENA     = q_ena_q;
    assign Q_DATAIN  = q_datain_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_BYTES = out_bytes_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        real_cnt_d   = real_cnt_q;
        flush_pend_d = flush_pend_q;
        idle_cnt_d   = idle_cnt_q;
        q_datain_d   = q_datain_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending flush (explicit or timeout) starts padding from rest.
                if (flush_pend_q) begin
                    state_d    = PAD;
                    q_datain_d = PAD_BYTE;
                end else if (accept) begin
                    state_d    = SHIFT;
                    q_datain_d = IN_DATA;
                end
            end
            SHIFT: begin
                cnt_d      = cnt_q + 3'd1;
                real_cnt_d = real_cnt_q + 3'd1;
                state_d    = GAP;
            end
            GAP: begin
                if (cnt_q == 3'd4) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (flush_pend_q) begin
                    state_d    = PAD;
                    q_datain_d = PAD_BYTE;
                end else if (accept) begin
                    state_d    = SHIFT;
                    q_datain_d = IN_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            PAD: begin
                cnt_d   = cnt_q + 3'd1;
                state_d = PADGAP;
            end
            PADGAP: begin
                if (cnt_q == 3'd4) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d    = PAD;
                    q_datain_d = PAD_BYTE;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    real_cnt_d = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        // In SHIFT the byte is already taken even though cnt has not moved yet.
        if (FLUSH && ((state_q == IDLE) || (state_q == SHIFT) || (state_q == GAP))
            && (partial || accept || (state_q == SHIFT)))
            flush_pend_d = 1'b1;

        if (accept || (cnt_q == 3'd0) || flush_pend_q) begin
            idle_cnt_d = '0;
        end else if ((state_q == IDLE) && (TIMEOUT_CYC != 0)) begin
            if (idle_cnt_q == IW'(TIMEOUT_CYC))
                flush_pend_d = 1'b1;
            else
                idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // Capture also drops a flush that raced with the 4th byte, so no
        // empty padded word follows a full one.
        if (capture) begin
            out_data_d   = Q_DATAOUT;
            out_bytes_d  = real_cnt_q;
            flush_pend_d = 1'b0;
        end

        q_ena_d     = (state_d == SHIFT) || (state_d == PAD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            real_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            idle_cnt_q   <= '0;
            q_ena_q      <= 1'b0;
            q_datain_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            real_cnt_q   <= real_cnt_d;
            flush_pend_q <= flush_pend_d;
            idle_cnt_q   <= idle_cnt_d;
            q_ena_q      <= q_ena_d;
            q_datain_q   <= q_datain_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
        end
    end

endmodule

// File: doc/queue_pack_ctrl.md
Name: queue_pack_ctrl

Overview:
- Sequencer that drives the 4x8-bit shift queue from a byte stream with a valid/ready handshake.
- Each accepted byte becomes one single-cycle ENA pulse into the queue. After 4 shifts it presents the queue's 32-bit word on a valid/ready output port.
- Supports partial-word flush, triggered explicitly or by idle timeout, by padding with a fill byte.
- Sits between the byte source and the word consumer. Owns the queue's ENA and DATAIN pins.

Parameters:
- TIMEOUT_CYC, 16, idle cycles with a partial word before an automatic flush; 0 disables the timeout.
- PAD_BYTE, 8'h00, fill byte shifted in during a flush.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  source byte valid.
- IN_DATA  in  8  source byte.
- IN_READY  out  1  controller can accept a byte.
- FLUSH  in  1  single-cycle request to emit the current partial word.
- Q_ENA  out  1  to queue ENA; the queue shifts on ENA rising edge.
- Q_DATAIN  out  8  to queue DATAIN.
- Q_DATAOUT  in  32  from queue DATAOUT; oldest byte in [31:24].
- OUT_VALID  out  1  word valid.
- OUT_DATA  out  32  packed word, oldest byte in [31:24].
- OUT_BYTES  out  3  real (non-pad) bytes in OUT_DATA, range 1..4.
- OUT_READY  in  1  consumer accepts the word.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high. RST also resets the queue.
- Reset state: state=IDLE, cnt=0, flush_pend=0, idle_cnt=0. Q_ENA=0, Q_DATAIN=0, OUT_VALID=0, OUT_DATA=0, OUT_BYTES=0. IN_READY is forced 0 while RST=1.
- Registered outputs: Q_ENA, Q_DATAIN, OUT_VALID, OUT_DATA and OUT_BYTES are registered.
- IN_READY (combinational): IN_READY = (state==IDLE or state==GAP) and cnt<4 and !flush_pend and !RST.
- States:
  - IDLE: Q_ENA=0. A handshake (IN_VALID & IN_READY) moves to SHIFT and registers IN_DATA into Q_DATAIN.
  - SHIFT: Q_ENA=1 for exactly 1 cycle; cnt+1; real_cnt+1. Always moves to GAP.
  - GAP: Q_ENA=0, so the queue edge detector sees a falling edge.
    - If cnt==4: capture Q_DATAOUT into OUT_DATA and real_cnt into OUT_BYTES, then go to HOLD.
    - Else if flush_pend: go to PAD.
    - Else a handshake goes to SHIFT; otherwise go to IDLE.
  - PAD: Q_DATAIN=PAD_BYTE, Q_ENA=1, cnt+1; real_cnt is unchanged. Always moves to PADGAP.
  - PADGAP: Q_ENA=0. If cnt==4: capture into OUT_DATA/OUT_BYTES, clear flush_pend, go to HOLD. Else go to PAD.
  - HOLD: OUT_VALID=1; OUT_DATA and OUT_BYTES are stable. When OUT_READY=1: next cycle OUT_VALID=0, cnt=0, real_cnt=0, state IDLE.
- Throughput: max 1 byte per 2 cycles, because ENA must toggle.
- Latency: 4th byte accepted at cycle t gives SHIFT at t+1, GAP at t+2, OUT_VALID=1 from t+3.
- FLUSH:
  - Sets flush_pend only if cnt is in 1..3, or a byte is being accepted in the same cycle. The byte is taken first, then padding follows.
  - FLUSH with cnt==0 and no accept is ignored.
  - FLUSH during HOLD or PAD is ignored.
- Timeout:
  - idle_cnt counts cycles in IDLE with 1<=cnt<=3.
  - It resets on any accept, and whenever cnt==0 or a flush is pending.
  - When idle_cnt reaches TIMEOUT_CYC, flush_pend is set.
  - With TIMEOUT_CYC==0 the timeout never fires.
- Padding example: bytes A,B then flush gives OUT_DATA={A,B,PAD,PAD}, OUT_BYTES=2.
- Backpressure: in HOLD, IN_READY=0 and no Q_ENA pulses occur. Q_DATAOUT is not sampled again until the next GAP or PADGAP.
- Reset mid-operation: RST in any state returns immediately to reset values. Any partial or held word is discarded; nothing is emitted.

Test Plan:
- Reset, then IN_VALID=1 continuously with 0x11,0x22,0x33,0x44, OUT_READY=1:
  - Q_ENA is high on alternate cycles, 4 pulses.
  - OUT_VALID=1 three cycles after the 4th accept, with OUT_DATA=0x11223344 and OUT_BYTES=4.
- Same stream with OUT_READY=0 for 10 cycles:
  - OUT_VALID and OUT_DATA=0x11223344 stay stable; IN_READY=0; Q_ENA stays 0.
  - Asserting OUT_READY gives OUT_VALID=0 next cycle and IN_READY=1.
- Bytes 0xAA,0xBB, then FLUSH pulse, PAD_BYTE=0x00:
  - Exactly 2 PAD pulses with Q_DATAIN=0x00.
  - OUT_DATA=0xAABB0000, OUT_BYTES=2.
- TIMEOUT_CYC=16, single byte 0x5A, then IN_VALID=0:
  - Padding starts after 16 idle cycles; OUT_DATA=0x5A000000, OUT_BYTES=1.
  - With cnt=0, 100 idle cycles produce no output.
- FLUSH with cnt=0 gives no Q_ENA pulse and no OUT_VALID.
- FLUSH in the same cycle as accepting the 3rd byte 0x33 (after 0x11,0x22):
  - OUT_DATA=0x11223300, OUT_BYTES=3.
- RST asserted during PAD after 0x01,0x02:
  - All outputs read 0 immediately.
  - After release, IN_READY=1, and next bytes 0xC0..0xC3 produce 0xC0C1C2C3 with OUT_BYTES=4.
